bp_bimodal: RTL and testbench
=============================

Name: bp_bimodal

Overview:
- Parametrised next-PC predictor in the fetch loop, between the instruction cache and instruction fetch (inf).
- When the instruction cache returns an instruction, the block decodes it and predicts the next PC one cycle later:
  - JAL: always taken to its target.
  - B-type: taken or not-taken from a table of 2-bit saturating counters indexed by PC.
  - Everything else: PC+4.
- Counters are trained by branch-resolution results from the ROB.
- A flush input squashes any prediction in flight.

Parameters:
- IDX_W, 8, log2 of counter-table entries (256 entries); index = pc[IDX_W+1:2].
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).
- ADDR_W, 32, PC width (matches `AddrBus).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; all state holds when low
- iIC_en  in  1  instruction valid from instruction cache this cycle
- iIC_inst  in  32  fetched instruction (`InstBus)
- iINF_en  in  1  inf request valid; informational only, predictions are gated by iIC_en
- iINF_pc  in  ADDR_W  PC of iIC_inst, valid with iIC_en
- oINF_en  out  1  prediction valid, one-cycle pulse
- oINF_ppc  out  ADDR_W  predicted next PC
- oINF_taken  out  1  prediction was taken (JAL, or B-type with counter>=2)
- iROB_upd  in  1  resolved conditional branch commit
- iROB_pc  in  ADDR_W  PC of resolved branch
- iROB_taken  in  1  actual branch outcome
- iROB_clr  in  1  pipeline flush (mispredict)

Behaviour:
- Reset (rst=1 at posedge):
  - oINF_en=0, oINF_ppc=0, oINF_taken=0.
  - All 2^IDX_W counters set to CNT_INIT.
  - Reset mid-operation discards the pending prediction and any same-cycle update.
- rdy=0: no register or counter changes; outputs hold previous values. rst has priority over rdy.
- Prediction, latency 1 cycle (registered outputs):
  - When rdy and iIC_en and !iIC_clr-condition (below), next cycle oINF_en=1.
  - Decode opcode = iIC_inst[6:0]:
    - 7'b1101111 (JAL): immJ = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}). ppc = pc+immJ, taken=1.
    - 7'b1100011 (B-type): immB = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}). cnt = table[pc[IDX_W+1:2]]. If cnt[1]: ppc = pc+immB, taken=1; else ppc = pc+4, taken=0.
    - Any other opcode, including JALR: ppc = pc+4, taken=0.
  - Address adds are ADDR_W-bit modular; wrap at 2^ADDR_W is silent.
- When !iIC_en: oINF_en=0 next cycle; oINF_ppc and oINF_taken hold.
- Flush: iROB_clr=1 forces oINF_en=0 next cycle regardless of iIC_en. Counter updates in the same cycle still apply.
- Update:
  - On rdy and iROB_upd, entry e = iROB_pc[IDX_W+1:2].
  - taken: e = min(e+1, 3). Not taken: e = max(e-1, 0). Saturating; no wrap 3->0 or 0->3.
- Simultaneous predict and update to the same index: the prediction uses the pre-update counter value (read-old). The update is visible from the next cycle.
- No tags: aliasing between PCs sharing an index is permitted.
- iROB_upd concerns conditional branches only. The ROB never sends JAL/JALR here; if it does, the counter is updated anyway.

Decomposition:
- Shared package/config.v:
  - `AddrBus, `InstBus.
  - Opcode constants `OP_JAL=7'b1101111, `OP_BRANCH=7'b1100011.
  - Counter constants `CNT_SNT=0 .. `CNT_ST=3.
- Sub-module bp_cnt_table(IDX_W, CNT_INIT):
  - 2^IDX_W x 2-bit array.
  - Combinational read port (ridx -> rcnt).
  - One synchronous saturating-update port (we, widx, taken).
  - Synchronous reset to CNT_INIT.
- Immediate extraction stays in bp_bimodal as combinational logic.

Test Plan:
- Reset: assert rst 2 cycles -> oINF_en=0, oINF_ppc=0, oINF_taken=0. Every table entry reads 2'b01 (spot-check idx 0, 255).
- Non-branch: iIC_en=1, pc=0x100, inst=0x00000013 (addi) -> next cycle oINF_en=1, ppc=0x104, taken=0. Following cycle with iIC_en=0 -> oINF_en=0.
- JAL: pc=0x200, inst=0x0080006F (jal x0,+8) -> ppc=0x208, taken=1. Negative case: inst=0xFF9FF06F (jal -8) at 0x200 -> ppc=0x1F8.
- Branch training:
  - beq +16 (0x00000863) at 0x300 predicts ppc=0x304, taken=0.
  - Then iROB_upd taken twice at 0x300 -> counter 3; same fetch -> ppc=0x310, taken=1.
  - Three more taken updates keep counter at 3.
  - Four not-taken updates -> 0; two more keep it at 0.
- Same-cycle collision: counter=1 at 0x300; predict at 0x300 with iROB_upd taken the same cycle -> taken=0. Repeat next cycle -> taken=1.
- Control: rdy=0 with iIC_en=1 and iROB_upd=1 -> outputs and counters unchanged. iROB_clr=1 with iIC_en=1 -> oINF_en=0 next cycle. rst asserted the cycle after iIC_en -> oINF_en=0.

Source files
------------

// File: rtl/bp_bimodal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_bimodal_pkg
//  Description : Shared bus widths, opcode and counter constants, and the
//                2-bit saturating counter step used by the bimodal predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_bimodal_pkg;

    localparam int c_ADDR_BUS_W = 32;
    localparam int c_INST_BUS_W = 32;

    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [1:0] c_CNT_SNT = 2'd0;
    localparam logic [1:0] c_CNT_WNT = 2'd1;
    localparam logic [1:0] c_CNT_WT  = 2'd2;
    localparam logic [1:0] c_CNT_ST  = 2'd3;

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] r;
        r = cnt;
        if (taken) begin
            if (cnt != c_CNT_ST) r = cnt + 2'd1;
        end else begin
            if (cnt != c_CNT_SNT) r = cnt - 2'd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_bimodal_cnt_table.sv
`default_nettype none
// ============================================================================
//  Module      : bp_cnt_table
//  Description : 2^IDX_W entry table of 2-bit saturating counters with a
//                combinational read port and one synchronous update port.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_cnt_table
    import bp_bimodal_pkg::*;
#(
    parameter int         IDX_W    = 8,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] ridx,
    output logic [1:0]       rcnt,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic             taken
);

    localparam int c_DEPTH = 1 << IDX_W;

    logic [1:0] r_cnt [c_DEPTH];

    // Read returns the pre-update value when read and write hit the same entry.
    assign rcnt = r_cnt[ridx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_cnt[i] <= CNT_INIT;
            end
        end else if (we) begin
            r_cnt[widx] <= cnt_next(r_cnt[widx], taken);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_bimodal.sv
`default_nettype none
// ============================================================================
//  Module      : bp_bimodal
//  Description : Bimodal next-PC predictor: decodes the fetched instruction
//                and registers a JAL / B-type / PC+4 prediction one cycle on.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_bimodal
    import bp_bimodal_pkg::*;
#(
    parameter int         IDX_W    = 8,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         ADDR_W   = c_ADDR_BUS_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    iIC_en,
    input  logic [c_INST_BUS_W-1:0] iIC_inst,
    input  logic                    iINF_en,
    input  logic [ADDR_W-1:0]       iINF_pc,
    output logic                    oINF_en,
    output logic [ADDR_W-1:0]       oINF_ppc,
    output logic                    oINF_taken,
    input  logic                    iROB_upd,
    input  logic [ADDR_W-1:0]       iROB_pc,
    input  logic                    iROB_taken,
    input  logic                    iROB_clr
);

    logic [6:0]        w_opcode;
    logic [ADDR_W-1:0] w_imm_j;
    logic [ADDR_W-1:0] w_imm_b;
    logic [IDX_W-1:0]  w_ridx;
    logic [IDX_W-1:0]  w_widx;
    logic [1:0]        w_rcnt;
    logic              w_we;
    logic              w_fire;
    logic [ADDR_W-1:0] w_ppc;
    logic              w_taken;

    logic              r_en;
    logic [ADDR_W-1:0] r_ppc;
    logic              r_taken;

    assign w_opcode = iIC_inst[6:0];
    assign w_imm_j  = {{(ADDR_W-21){iIC_inst[31]}}, iIC_inst[31], iIC_inst[19:12],
                       iIC_inst[20], iIC_inst[30:21], 1'b0};
    assign w_imm_b  = {{(ADDR_W-13){iIC_inst[31]}}, iIC_inst[31], iIC_inst[7],
                       iIC_inst[30:25], iIC_inst[11:8], 1'b0};

    assign w_ridx = iINF_pc[IDX_W+1:2];
    assign w_widx = iROB_pc[IDX_W+1:2];
    assign w_we   = rdy & iROB_upd;
    assign w_fire = iIC_en & ~iROB_clr;

    // Request-side handshake and alignment/high PC bits carry no information here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, iINF_en, iROB_pc[1:0], iROB_pc[ADDR_W-1:IDX_W+2]};

    bp_cnt_table #(
        .IDX_W    (IDX_W),
        .CNT_INIT (CNT_INIT)
    ) u_cnt_table (
        .clk   (clk),
        .rst   (rst),
        .ridx  (w_ridx),
        .rcnt  (w_rcnt),
        .we    (w_we),
        .widx  (w_widx),
        .taken (iROB_taken)
    );

    always_comb begin
        w_ppc   = iINF_pc + ADDR_W'(4);
        w_taken = 1'b0;
        if (w_opcode == c_OP_JAL) begin
            w_ppc   = iINF_pc + w_imm_j;
            w_taken = 1'b1;
        end else if (w_opcode == c_OP_BRANCH && w_rcnt[1]) begin
            w_ppc   = iINF_pc + w_imm_b;
            w_taken = 1'b1;
        end
    end

    // A squashed or absent fetch leaves the last prediction visible but not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en    <= 1'b0;
            r_ppc   <= '0;
            r_taken <= 1'b0;
        end else if (rdy) begin
            r_en <= w_fire;
            if (w_fire) begin
                r_ppc   <= w_ppc;
                r_taken <= w_taken;
            end
        end
    end

    assign oINF_en    = r_en;
    assign oINF_ppc   = r_ppc;
    assign oINF_taken = r_taken;

endmodule
`default_nettype wire

// File: tb/tb_bp_bimodal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_bimodal
//  Description : Directed vector bench for bp_bimodal with hand-computed
//                predictions and counter training sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_bimodal;

    localparam logic [31:0] c_ADDI  = 32'h0000_0013;
    localparam logic [31:0] c_JALP8 = 32'h0080_006F;
    localparam logic [31:0] c_JALM8 = 32'hFF9F_F06F;
    localparam logic [31:0] c_BEQ16 = 32'h0000_0863;
    localparam logic [31:0] c_BEQM  = 32'hFE00_08E3;
    localparam logic [31:0] c_JALR  = 32'h0000_8067;

    logic        clk = 1'b0;
    logic        rst, rdy, ic_en, inf_en, upd, upd_tk, clr;
    logic [31:0] inst, pc, upd_pc;
    logic        o_en, o_tk;
    logic [31:0] o_ppc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_bimodal dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .iIC_en     (ic_en),
        .iIC_inst   (inst),
        .iINF_en    (inf_en),
        .iINF_pc    (pc),
        .oINF_en    (o_en),
        .oINF_ppc   (o_ppc),
        .oINF_taken (o_tk),
        .iROB_upd   (upd),
        .iROB_pc    (upd_pc),
        .iROB_taken (upd_tk),
        .iROB_clr   (clr)
    );

    typedef struct {
        logic        rdy;
        logic        ic_en;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        upd;
        logic [31:0] upd_pc;
        logic        upd_tk;
        logic        clr;
        logic        exp_en;
        logic [31:0] exp_ppc;
        logic        exp_tk;
    } vec_t;

    vec_t vecs [36];

    function automatic vec_t mk(input logic r, input logic ie, input logic [31:0] in,
                                input logic [31:0] p, input logic u, input logic [31:0] up,
                                input logic ut, input logic c, input logic ee,
                                input logic [31:0] ep, input logic et);
        vec_t v;
        v.rdy = r; v.ic_en = ie; v.inst = in; v.pc = p;
        v.upd = u; v.upd_pc = up; v.upd_tk = ut; v.clr = c;
        v.exp_en = ee; v.exp_ppc = ep; v.exp_tk = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ee, input logic [31:0] ep, input logic et);
        chk({tag, "_en"}, {31'd0, o_en}, {31'd0, ee});
        chk({tag, "_ppc"}, o_ppc, ep);
        chk({tag, "_taken"}, {31'd0, o_tk}, {31'd0, et});
    endtask

    initial begin
        //                  rdy ie  inst     pc            upd up          ut  clr   en  ppc           tk
        vecs[0]  = mk(1, 1, c_ADDI,  32'h100,      0, 0,          0, 0,   1, 32'h104,      0);
        vecs[1]  = mk(1, 0, c_ADDI,  32'h100,      0, 0,          0, 0,   0, 32'h104,      0);
        vecs[2]  = mk(1, 1, c_JALP8, 32'h200,      0, 0,          0, 0,   1, 32'h208,      1);
        vecs[3]  = mk(1, 1, c_JALM8, 32'h200,      0, 0,          0, 0,   1, 32'h1F8,      1);
        vecs[4]  = mk(1, 1, c_BEQ16, 32'h300,      0, 0,          0, 0,   1, 32'h304,      0);
        vecs[5]  = mk(1, 0, 0,       0,            1, 32'h300,    1, 0,   0, 32'h304,      0);
        vecs[6]  = mk(1, 0, 0,       0,            1, 32'h300,    1, 0,   0, 32'h304,      0);
        vecs[7]  = mk(1, 1, c_BEQ16, 32'h300,      0, 0,          0, 0,   1, 32'h310,      1);
        vecs[8]  = mk(1, 0, 0,       0,            1, 32'h300,    1, 0,   0, 32'h310,      1);
        vecs[9]  = mk(1, 0, 0,       0,            1, 32'h300,    1, 0,   0, 32'h310,      1);
        vecs[10] = mk(1, 0, 0,       0,            1, 32'h300,    1, 0,   0, 32'h310,      1);
        vecs[11] = mk(1, 0, 0,       0,            1, 32'h300,    0, 0,   0, 32'h310,      1);
        vecs[12] = mk(1, 1, c_BEQ16, 32'h300,      0, 0,          0, 0,   1, 32'h310,      1);
        vecs[13] = mk(1, 0, 0,       0,            1, 32'h300,    0, 0,   0, 32'h310,      1);
        vecs[14] = mk(1, 0, 0,       0,            1, 32'h300,    0, 0,   0, 32'h310,      1);
        vecs[15] = mk(1, 0, 0,       0,            1, 32'h300,    0, 0,   0, 32'h310,      1);
        vecs[16] = mk(1, 0, 0,       0,            1, 32'h300,    0, 0,   0, 32'h310,      1);
        vecs[17] = mk(1, 0, 0,       0,            1, 32'h300,    0, 0,   0, 32'h310,      1);
        vecs[18] = mk(1, 0, 0,       0,            1, 32'h300,    1, 0,   0, 32'h310,      1);
        vecs[19] = mk(1, 1, c_BEQ16, 32'h300,      0, 0,          0, 0,   1, 32'h304,      0);
        vecs[20] = mk(1, 1, c_BEQ16, 32'h300,      1, 32'h300,    1, 0,   1, 32'h304,      0);
        vecs[21] = mk(1, 1, c_BEQ16, 32'h300,      0, 0,          0, 0,   1, 32'h310,      1);
        vecs[22] = mk(1, 1, c_BEQ16, 32'h300,      1, 32'h300,    0, 1,   0, 32'h310,      1);
        vecs[23] = mk(1, 1, c_BEQ16, 32'h300,      0, 0,          0, 0,   1, 32'h304,      0);
        vecs[24] = mk(0, 1, c_ADDI,  32'h100,      1, 32'h300,    1, 0,   1, 32'h304,      0);
        vecs[25] = mk(1, 1, c_BEQ16, 32'h300,      0, 0,          0, 0,   1, 32'h304,      0);
        vecs[26] = mk(1, 0, 0,       0,            1, 32'h700,    1, 0,   0, 32'h304,      0);
        vecs[27] = mk(1, 1, c_BEQ16, 32'h300,      0, 0,          0, 0,   1, 32'h310,      1);
        vecs[28] = mk(1, 0, 0,       0,            1, 32'h3FC,    1, 0,   0, 32'h310,      1);
        vecs[29] = mk(1, 1, c_BEQ16, 32'h3FC,      0, 0,          0, 0,   1, 32'h40C,      1);
        vecs[30] = mk(1, 1, c_BEQ16, 32'h0,        0, 0,          0, 0,   1, 32'h004,      0);
        vecs[31] = mk(1, 0, 0,       0,            1, 32'h0,      1, 0,   0, 32'h004,      0);
        vecs[32] = mk(1, 1, c_BEQ16, 32'h0,        0, 0,          0, 0,   1, 32'h010,      1);
        vecs[33] = mk(1, 1, c_JALP8, 32'hFFFFFFFC, 0, 0,          0, 0,   1, 32'h004,      1);
        vecs[34] = mk(1, 1, c_JALR,  32'h500,      0, 0,          0, 0,   1, 32'h504,      0);
        vecs[35] = mk(1, 1, c_BEQM,  32'h300,      0, 0,          0, 0,   1, 32'h2F0,      1);

        rst = 1; rdy = 1; ic_en = 0; inf_en = 0; upd = 0; upd_tk = 0; clr = 0;
        inst = 0; pc = 0; upd_pc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 36; i++) begin
            rdy = vecs[i].rdy; ic_en = vecs[i].ic_en; inf_en = vecs[i].ic_en;
            inst = vecs[i].inst; pc = vecs[i].pc;
            upd = vecs[i].upd; upd_pc = vecs[i].upd_pc; upd_tk = vecs[i].upd_tk;
            clr = vecs[i].clr;
            @(posedge clk);
            #1;
            chk_out($sformatf("v%0d", i), vecs[i].exp_en, vecs[i].exp_ppc, vecs[i].exp_tk);
            @(negedge clk);
        end

        // Reset in the same cycle as a fetch discards it and restores the table.
        rdy = 1; upd = 0; clr = 0;
        ic_en = 1; inst = c_ADDI; pc = 32'h100; rst = 1;
        @(posedge clk); #1;
        chk_out("rst_same", 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 0; inst = c_BEQ16; pc = 32'h300;
        @(posedge clk); #1;
        chk_out("rst_table", 1'b1, 32'h304, 1'b0);

        // Reset the cycle after a fetch clears the just-produced prediction.
        @(negedge clk);
        inst = c_ADDI; pc = 32'h100;
        @(posedge clk); #1;
        chk_out("pre_rst", 1'b1, 32'h104, 1'b0);
        @(negedge clk);
        ic_en = 0; rst = 1;
        @(posedge clk); #1;
        chk_out("rst_after", 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
